// File: rtl/tree_decode.sv
// Huffman tree-walk decoder: locates the root in the shared tree memory, then follows
// one tree entry per serial code bit and emits a symbol whenever the walk reaches a leaf.
module tree_decode #(
  parameter int unsigned NODE_BASE = 256,
  parameter logic [7:0]  END_MARK  = 8'hFF,
  parameter int unsigned MAX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       decode_start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bit_last,
  output logic       bit_ready,
  output logic [7:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [9:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  output logic       decode_finish,
  output logic       decode_err
);

  localparam logic [3:0] DEPTH_LIMIT = 4'(MAX_DEPTH);
  localparam logic [7:0] FIRST_NODE  = 8'd128;
  localparam logic [7:0] LAST_SCAN   = 8'd254;

  typedef enum logic [3:0] {
    IDLE, FIND, RWAIT, RCHECK, GET_BIT, FETCH, FWAIT, CHECK, EMIT, DONE, ERR
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] node_q;
  logic [7:0] root_q;
  logic [3:0] depth_q;
  logic       last_q;

  // Entry k of internal node (128+idx); 10-bit result tops out at NODE_BASE+127*3+2.
  function automatic logic [9:0] entry_addr(input logic [6:0] idx, input logic [1:0] entry);
    return 10'(NODE_BASE) + ({3'b000, idx} * 10'd3) + {8'b0, entry};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (decode_start) state_nxt = FIND;
      FIND:    state_nxt = RWAIT;
      RWAIT:   state_nxt = RCHECK;
      RCHECK: begin
        if (mem_data == END_MARK)   state_nxt = (node_q == FIRST_NODE) ? ERR : GET_BIT;
        else if (node_q == LAST_SCAN) state_nxt = ERR;
        else                        state_nxt = FIND;
      end
      GET_BIT: if (bit_valid) state_nxt = FETCH;
      FETCH:   state_nxt = FWAIT;
      FWAIT:   state_nxt = CHECK;
      CHECK: begin
        if (!mem_data[7])                            state_nxt = EMIT;
        else if ((depth_q == DEPTH_LIMIT) || last_q) state_nxt = ERR;
        else                                         state_nxt = GET_BIT;
      end
      EMIT:    if (sym_ready) state_nxt = last_q ? DONE : GET_BIT;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bit_ready     = (state == GET_BIT);
  assign sym_valid     = (state == EMIT);
  assign decode_finish = (state == DONE);

  // Memory strobe and address are registered so they are present during FIND/FETCH themselves.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      sym_out    <= '0;
      decode_err <= 1'b0;
      node_q     <= FIRST_NODE;
      root_q     <= FIRST_NODE;
      depth_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      mem_rd <= (state_nxt == FIND) || (state_nxt == RWAIT) ||
                (state_nxt == FETCH) || (state_nxt == FWAIT);
      if (state_nxt == ERR) decode_err <= 1'b1;
      case (state)
        IDLE: if (decode_start) begin
          decode_err <= 1'b0;
          node_q     <= FIRST_NODE;
          depth_q    <= '0;
          last_q     <= 1'b0;
          mem_addr   <= entry_addr(7'd0, 2'd0);
        end
        RCHECK: begin
          if (mem_data == END_MARK) begin
            if (node_q != FIRST_NODE) begin
              root_q <= node_q - 8'd1;
              node_q <= node_q - 8'd1;
            end
            depth_q <= '0;
          end else begin
            node_q   <= node_q + 8'd1;
            mem_addr <= entry_addr(node_q[6:0] + 7'd1, 2'd0);
          end
        end
        GET_BIT: if (bit_valid) begin
          last_q   <= bit_last;
          mem_addr <= entry_addr(node_q[6:0], bit_in ? 2'd1 : 2'd2);
        end
        FWAIT: depth_q <= depth_q + 4'd1;
        CHECK: begin
          if (!mem_data[7]) sym_out <= mem_data;
          else              node_q  <= mem_data;
        end
        EMIT: if (sym_ready) begin
          node_q  <= root_q;
          depth_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_decode.sv
// Bench for tree_decode: tree memory with 2-cycle read latency, directed and randomized
// trees/streams, and a tree-walk reference model that predicts symbols, bit usage and outcome.
module tb_tree_decode;
  logic       clk = 1'b0;
  logic       reset, decode_start, bit_in, bit_valid, bit_last, bit_ready;
  logic [7:0] sym_out;
  logic       sym_valid, sym_ready;
  logic [9:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       decode_finish, decode_err;

  always #5 clk = ~clk;

  tree_decode dut (
    .clk(clk), .reset(reset), .decode_start(decode_start),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .decode_finish(decode_finish), .decode_err(decode_err)
  );

  logic [7:0] mem [0:1023];
  logic [7:0] mem_d1;
  always @(posedge clk) begin
    mem_d1   <= mem[mem_addr];
    mem_data <= mem_d1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model
  int stim_bits[$];
  int exp_syms[$];
  int exp_err, exp_used;
  int tree_root;

  function automatic int ent(input int node, input int k);
    return 256 + (node - 128) * 3 + k;
  endfunction

  task automatic model_decode();
    int n, root, node, depth, v;
    exp_syms.delete();
    exp_err = 0; exp_used = 0; root = -1; n = 128;
    while (root < 0 && exp_err == 0) begin
      if (mem[ent(n, 0)] == 8'hFF) begin
        if (n == 128) exp_err = 1;
        else root = n - 1;
      end else if (n == 254) exp_err = 1;
      else n++;
    end
    if (exp_err != 0) return;
    node = root; depth = 0;
    for (int i = 0; i < stim_bits.size(); i++) begin
      exp_used++;
      v = int'(mem[ent(node, (stim_bits[i] != 0) ? 1 : 2)]);
      depth++;
      if (v < 128) begin
        exp_syms.push_back(v);
        node = root; depth = 0;
        if (i == stim_bits.size() - 1) return;
      end else begin
        node = v;
        if (depth == 8 || i == stim_bits.size() - 1) begin
          exp_err = 1;
          return;
        end
      end
    end
  endtask

  // Compare process
  bit         checking = 1'b0;
  int         cyc = 0, start_cyc = 0, finish_cyc = 0;
  int         got_finish, got_err, bits_used, ready_cycles;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_sym;

  always @(negedge clk) begin
    cyc++;
    if (decode_start) start_cyc = cyc;
    if (checking) begin
      check("valid_ready_exclusive", int'(sym_valid && bit_ready), 0);
      if (mem_rd) check("addr_range", int'(mem_addr >= 10'd256 && mem_addr <= 10'd639), 1);
      if (prev_hold) begin
        check("sym_valid_held", int'(sym_valid), 1);
        check("sym_out_held", int'(sym_out), int'(prev_sym));
      end
      if (bit_ready) ready_cycles++;
      if (bit_valid && bit_ready) bits_used++;
      if (sym_valid && sym_ready) begin
        if (exp_syms.size() == 0) check("extra_symbol", int'(sym_out), -1);
        else check("symbol", int'(sym_out), exp_syms.pop_front());
      end
      if (decode_finish) begin
        got_finish++;
        finish_cyc = cyc;
      end
      if (decode_err) got_err = 1;
      prev_hold = sym_valid && !sym_ready;
      prev_sym  = sym_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ready_mode: 0 always ready, 1 five-cycle stall per symbol, 2 random
  task automatic run_decode(input int ready_mode, input bit full_valid, input int budget);
    int idx, stall, cycles;
    model_decode();
    idx = 0; stall = 0; cycles = 0;
    got_finish = 0; got_err = 0; bits_used = 0; ready_cycles = 0;
    bit_valid = 1'b0; sym_ready = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
    @(posedge clk); #1 decode_start = 1'b1;
    @(posedge clk); #1 decode_start = 1'b0;
    checking = 1'b1;
    while (cycles < budget && got_finish == 0 && got_err == 0) begin
      bit_valid = (idx < stim_bits.size()) && (full_valid || $urandom_range(0, 2) != 0);
      bit_in    = (idx < stim_bits.size()) ? (stim_bits[idx] != 0) : 1'b0;
      bit_last  = (idx == stim_bits.size() - 1);
      case (ready_mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = (stall >= 5);
        default: sym_ready = ($urandom_range(0, 1) != 0);
      endcase
      @(negedge clk);
      if (bit_valid && bit_ready) idx++;
      if (ready_mode == 1) stall = (sym_valid && !sym_ready) ? stall + 1 : 0;
      @(posedge clk); #1;
      cycles++;
    end
    if (got_finish == 0 && got_err == 0) check("decode_timeout", 0, 1);
    bit_valid = 1'b0; sym_ready = 1'b0; bit_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 checking = 1'b0;
    check("finish_pulses", got_finish, (exp_err != 0) ? 0 : 1);
    check("decode_err", int'(decode_err), exp_err);
    check("bits_consumed", bits_used, exp_used);
    check("symbols_missing", exp_syms.size(), 0);
    check("idle_bit_ready", int'(bit_ready), 0);
    check("idle_sym_valid", int'(sym_valid), 0);
  endtask

  task automatic clear_tree();
    for (int a = 256; a < 1024; a++) mem[a] = 8'h00;
  endtask

  task automatic load_small_tree();
    clear_tree();
    mem[256] = 8'd129; mem[257] = 8'h42; mem[258] = 8'h41;
    mem[259] = 8'h00;  mem[260] = 8'd128; mem[261] = 8'h43;
    mem[262] = 8'hFF;
    tree_root = 129;
  endtask

  task automatic build_random_tree(input int nleaf);
    int items[$];
    bit used [128];
    int n, s, ia, a, b;
    clear_tree();
    for (int i = 0; i < 128; i++) used[i] = 1'b0;
    for (int i = 0; i < nleaf; i++) begin
      do s = $urandom_range(0, 127); while (used[s]);
      used[s] = 1'b1;
      items.push_back(s);
    end
    n = 128;
    while (items.size() > 1) begin
      ia = $urandom_range(0, items.size() - 1); a = items[ia]; items.delete(ia);
      ia = $urandom_range(0, items.size() - 1); b = items[ia]; items.delete(ia);
      mem[ent(n, 1)] = 8'(a);
      mem[ent(n, 2)] = 8'(b);
      items.push_back(n);
      n++;
    end
    mem[ent(n, 0)] = 8'hFF;
    tree_root = n - 1;
  endtask

  task automatic gen_walk_stream(input int nsym);
    int node, v, b;
    stim_bits.delete();
    for (int s = 0; s < nsym; s++) begin
      node = tree_root;
      for (int d = 0; d < 12; d++) begin
        b = $urandom_range(0, 1);
        stim_bits.push_back(b);
        v = int'(mem[ent(node, (b != 0) ? 1 : 2)]);
        if (v < 128) break;
        node = v;
      end
    end
  endtask

  initial begin
    int got_xfer;
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    reset = 1'b1; decode_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    bit_last = 1'b0; sym_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mem_addr", int'(mem_addr), 0);
    check("reset_mem_rd", int'(mem_rd), 0);
    check("reset_bit_ready", int'(bit_ready), 0);
    check("reset_sym_out", int'(sym_out), 0);
    check("reset_sym_valid", int'(sym_valid), 0);
    check("reset_finish", int'(decode_finish), 0);
    check("reset_err", int'(decode_err), 0);

    // 1) basic stream at full rate, with pinned model output and latency
    load_small_tree();
    stim_bits = '{1, 0, 0, 1, 1};
    model_decode();
    check("model_nsym", exp_syms.size(), 3);
    check("model_sym0", exp_syms[0], 'h41);
    check("model_sym1", exp_syms[1], 'h43);
    check("model_sym2", exp_syms[2], 'h42);
    check("model_err", exp_err, 0);
    run_decode(0, 1'b1, 200);
    check("start_to_finish_cycles", finish_cyc - start_cyc, 33);

    // 2) same stream, downstream stalls 5 cycles on each symbol
    run_decode(1, 1'b1, 300);

    // 3) empty tree
    mem[256] = 8'hFF;
    stim_bits = '{1, 0};
    run_decode(0, 1'b1, 100);
    check("empty_tree_model_err", exp_err, 1);
    check("empty_tree_ready_cycles", ready_cycles, 0);
    load_small_tree();

    // 4) stream ends on an internal node
    stim_bits = '{1};
    run_decode(0, 1'b1, 100);
    check("end_internal_model_used", exp_used, 1);

    // 5) chain deeper than the code length limit
    clear_tree();
    mem[ent(128, 1)] = 8'h10; mem[ent(128, 2)] = 8'h11;
    for (int n = 129; n <= 136; n++) begin
      mem[ent(n, 1)] = 8'(n - 1);
      mem[ent(n, 2)] = 8'(n - 129 + 8'h20);
    end
    mem[ent(137, 0)] = 8'hFF;
    stim_bits = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_decode(0, 1'b1, 200);
    check("deep_model_used", exp_used, 8);
    check("deep_model_err", exp_err, 1);

    // 6) reset during FWAIT
    load_small_tree();
    @(posedge clk); #1 decode_start = 1'b1;
    @(posedge clk); #1 decode_start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1; bit_last = 1'b0;
    got_xfer = 0;
    for (int i = 0; i < 60 && got_xfer == 0; i++) begin
      @(negedge clk);
      if (bit_ready) got_xfer = 1;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    check("reset_test_bit_taken", got_xfer, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("fwait_mem_rd", int'(mem_rd), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_mem_addr", int'(mem_addr), 0);
    check("midreset_mem_rd", int'(mem_rd), 0);
    check("midreset_bit_ready", int'(bit_ready), 0);
    check("midreset_sym_out", int'(sym_out), 0);
    check("midreset_sym_valid", int'(sym_valid), 0);
    check("midreset_err", int'(decode_err), 0);
    @(posedge clk); #1 reset = 1'b0;
    stim_bits = '{1, 0, 0, 1, 1};
    run_decode(2, 1'b0, 400);

    // Randomized trees, streams and handshakes
    for (int t = 0; t < 24; t++) begin
      build_random_tree($urandom_range(2, 16));
      if ((t % 3) == 2) begin
        stim_bits.delete();
        for (int i = 0; i < int'($urandom_range(1, 24)); i++)
          stim_bits.push_back(int'($urandom_range(0, 1)));
      end else begin
        gen_walk_stream($urandom_range(1, 6));
      end
      run_decode(2, ((t % 4) == 0), 3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
